// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the MCB user-port arbiter: MCB instruction codes,
// requester owner encoding, FSM state encodings and the read-tag layout.
package mem_port_arbiter_pkg;

   // MCB instruction encodings (bit0 set means read)
   localparam logic [2:0] MCB_CMD_WR = 3'b000;
   localparam logic [2:0] MCB_CMD_RD = 3'b001;

   // Owner of an outstanding read
   localparam logic OWNER_VGA = 1'b0;
   localparam logic OWNER_CPU = 1'b1;

   // Arbiter FSM states
   localparam logic [1:0] S_CALIB = 2'd0;
   localparam logic [1:0] S_ARB   = 2'd1;
   localparam logic [1:0] S_ISSUE = 2'd2;

   // One tag per outstanding read: who asked for it and how many words
   // (0-based) it will return.
   typedef struct packed {
      logic       owner;
      logic [5:0] bl;
   } tag_t;

   localparam int TAG_W = $bits(tag_t);

   // True when an MCB instruction returns data through the read FIFO.
   function automatic logic is_read_instr(input logic [2:0] instr);
      return instr[0];
   endfunction

endpackage

// File: rtl/mem_port_arbiter_tag_fifo.sv
// Synchronous FIFO holding the {owner, bl} tag of every outstanding read.
// The head entry is presented combinationally so the read-return logic can
// steer the current MCB read word without an extra cycle of latency.
module arb_tag_fifo
   import mem_port_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic clk,
   input  logic rst,
   input  logic push_i,
   input  tag_t push_data_i,
   input  logic pop_i,
   output logic full_o,
   output logic empty_o,
   output tag_t head_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW = AW + 1;

   tag_t          mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          push_ok;
   logic          pop_ok;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   // A push into a full FIFO or a pop from an empty one is dropped.
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   // Next pointer values; simultaneous push and pop both advance.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   // Pointer registers; reset discards every stored tag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Tag storage; contents are don't-care while the pointers say empty.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single MCB user port between the VGA read path and the
// CPU memory path. Commands are arbitrated, registered and issued one cycle
// later; a tag FIFO steers each returned read word to the requester that
// asked for it.
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to force a CPU grant after
// STARVE_LIMIT consecutive VGA grants while the CPU is waiting. Without it the
// VGA path has strict priority.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int TAG_DEPTH    = 4,
   parameter int STARVE_LIMIT = 4
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        calib_done,
   // VGA requester
   input  logic        vga_cmd_valid,
   output logic        vga_cmd_ready,
   input  logic [2:0]  vga_cmd_instr,
   input  logic [5:0]  vga_cmd_bl,
   input  logic [29:0] vga_cmd_byte_addr,
   input  logic        vga_rd_en,
   output logic        vga_rd_valid,
   // CPU requester
   input  logic        cpu_cmd_valid,
   output logic        cpu_cmd_ready,
   input  logic [2:0]  cpu_cmd_instr,
   input  logic [5:0]  cpu_cmd_bl,
   input  logic [29:0] cpu_cmd_byte_addr,
   input  logic        cpu_rd_en,
   output logic        cpu_rd_valid,
   // Read data broadcast to both requesters
   output logic [31:0] rd_data,
   // MCB command port
   output logic        mem_cmd_en,
   output logic [2:0]  mem_cmd_instr,
   output logic [5:0]  mem_cmd_bl,
   output logic [29:0] mem_cmd_byte_addr,
   input  logic        mem_cmd_full,
   // MCB read port
   output logic        mem_rd_en,
   input  logic [31:0] mem_rd_data,
   input  logic        mem_rd_empty,
   input  logic        mem_rd_overflow,
   input  logic        mem_rd_error,
   output logic        err
);

   logic [1:0]  state_q, state_d;
   logic [2:0]  cmd_instr_q;
   logic [5:0]  cmd_bl_q;
   logic [29:0] cmd_addr_q;
   logic [5:0]  word_cnt_q, word_cnt_d;
   logic        err_q;

   logic        force_cpu;
   logic        pick_vga;
   logic        pick_cpu;
   logic [2:0]  win_instr;
   logic [5:0]  win_bl;
   logic [29:0] win_addr;
   logic        win_read;
   logic        accept;
   logic        grant_vga;
   logic        grant_cpu;

   tag_t        push_tag;
   tag_t        head_tag;
   logic        tag_push;
   logic        tag_pop;
   logic        tag_full;
   logic        tag_empty;
   logic        rd_avail;
   logic        last_word;

   // ------------------------------------------------------------------
   // Starvation guard
   // ------------------------------------------------------------------
`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   logic [2:0] starve_q, starve_d;

   // Count back-to-back VGA wins while the CPU is kept waiting.
   always_comb begin
      starve_d = starve_q;
      if (!cpu_cmd_valid || grant_cpu) begin
         starve_d = 3'd0;
      end else if (grant_vga && (starve_q != 3'd7)) begin
         starve_d = starve_q + 3'd1;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q <= 3'd0;
      end else begin
         starve_q <= starve_d;
      end
   end

   assign force_cpu = cpu_cmd_valid && ({1'b0, starve_q} >= STARVE_MAX);
`else
   logic unused_starve_limit;
   assign unused_starve_limit = ^STARVE_LIMIT;
   assign force_cpu = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------

   // Pick the winner and decide whether it can be accepted this cycle.
   always_comb begin
      pick_vga  = vga_cmd_valid && !force_cpu;
      pick_cpu  = cpu_cmd_valid && !pick_vga;
      win_instr = pick_vga ? vga_cmd_instr     : cpu_cmd_instr;
      win_bl    = pick_vga ? vga_cmd_bl        : cpu_cmd_bl;
      win_addr  = pick_vga ? vga_cmd_byte_addr : cpu_cmd_byte_addr;
      win_read  = is_read_instr(win_instr);
      // A read that cannot get a tag blocks the port, even if the loser
      // holds a write; this keeps issue order equal to grant order.
      accept    = (state_q == S_ARB) && (pick_vga || pick_cpu) &&
                  !mem_cmd_full && !(win_read && tag_full);
      grant_vga = accept && pick_vga;
      grant_cpu = accept && pick_cpu;
   end

   assign vga_cmd_ready = grant_vga;
   assign cpu_cmd_ready = grant_cpu;

   // FSM: wait for calibration once, then alternate arbitrate / issue.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_CALIB: if (calib_done) state_d = S_ARB;
         S_ARB:   if (accept)     state_d = S_ISSUE;
         S_ISSUE:                 state_d = S_ARB;
         default:                 state_d = S_CALIB;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_CALIB;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture the winning command so it is stable while mem_cmd_en is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_instr_q <= 3'd0;
         cmd_bl_q    <= 6'd0;
         cmd_addr_q  <= 30'd0;
      end else if (accept) begin
         cmd_instr_q <= win_instr;
         cmd_bl_q    <= win_bl;
         cmd_addr_q  <= win_addr;
      end
   end

   assign mem_cmd_en        = (state_q == S_ISSUE);
   assign mem_cmd_instr     = cmd_instr_q;
   assign mem_cmd_bl        = cmd_bl_q;
   assign mem_cmd_byte_addr = cmd_addr_q;

   // ------------------------------------------------------------------
   // Read-return steering
   // ------------------------------------------------------------------
   assign tag_push       = accept && win_read;
   assign push_tag.owner = pick_vga ? OWNER_VGA : OWNER_CPU;
   assign push_tag.bl    = win_bl;

   arb_tag_fifo #(
      .DEPTH       (TAG_DEPTH)
   ) u_tag_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (tag_push),
      .push_data_i (push_tag),
      .pop_i       (tag_pop),
      .full_o      (tag_full),
      .empty_o     (tag_empty),
      .head_o      (head_tag)
   );

   // Only the owner of the head tag sees data; the other rd_en is ignored.
   always_comb begin
      rd_avail     = !mem_rd_empty && !tag_empty;
      vga_rd_valid = rd_avail && (head_tag.owner == OWNER_VGA);
      cpu_rd_valid = rd_avail && (head_tag.owner == OWNER_CPU);
      mem_rd_en    = (vga_rd_valid && vga_rd_en) || (cpu_rd_valid && cpu_rd_en);
      last_word    = (word_cnt_q == head_tag.bl);
      tag_pop      = mem_rd_en && last_word;
   end

   assign rd_data = mem_rd_data;

   // Word position inside the current burst; wraps to 0 on its last word.
   always_comb begin
      word_cnt_d = word_cnt_q;
      if (mem_rd_en) begin
         word_cnt_d = last_word ? 6'd0 : (word_cnt_q + 6'd1);
      end
   end

   // Word counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_cnt_q <= 6'd0;
      end else begin
         word_cnt_q <= word_cnt_d;
      end
   end

   // Sticky fault flag for read-FIFO overflow or error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (mem_rd_overflow || mem_rd_error) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Requester command queues and an
// MCB read-FIFO model drive the DUT; grants, issued commands and popped words
// are logged and compared with hand-computed expectations.
// Build with +define+MEM_ARB_STARVE_GUARD_EN to exercise the starvation guard.
module tb_mem_port_arbiter;

   typedef struct packed {
      logic [2:0]  instr;
      logic [5:0]  bl;
      logic [29:0] addr;
   } cmd_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        calib_done;
   logic        vga_cmd_valid, vga_cmd_ready, vga_rd_en, vga_rd_valid;
   logic [2:0]  vga_cmd_instr;
   logic [5:0]  vga_cmd_bl;
   logic [29:0] vga_cmd_byte_addr;
   logic        cpu_cmd_valid, cpu_cmd_ready, cpu_rd_en, cpu_rd_valid;
   logic [2:0]  cpu_cmd_instr;
   logic [5:0]  cpu_cmd_bl;
   logic [29:0] cpu_cmd_byte_addr;
   logic [31:0] rd_data;
   logic        mem_cmd_en;
   logic [2:0]  mem_cmd_instr;
   logic [5:0]  mem_cmd_bl;
   logic [29:0] mem_cmd_byte_addr;
   logic        mem_cmd_full;
   logic        mem_rd_en;
   logic [31:0] mem_rd_data;
   logic        mem_rd_empty, mem_rd_overflow, mem_rd_error;
   logic        err;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk               (clk),
      .rst               (rst),
      .calib_done        (calib_done),
      .vga_cmd_valid     (vga_cmd_valid),
      .vga_cmd_ready     (vga_cmd_ready),
      .vga_cmd_instr     (vga_cmd_instr),
      .vga_cmd_bl        (vga_cmd_bl),
      .vga_cmd_byte_addr (vga_cmd_byte_addr),
      .vga_rd_en         (vga_rd_en),
      .vga_rd_valid      (vga_rd_valid),
      .cpu_cmd_valid     (cpu_cmd_valid),
      .cpu_cmd_ready     (cpu_cmd_ready),
      .cpu_cmd_instr     (cpu_cmd_instr),
      .cpu_cmd_bl        (cpu_cmd_bl),
      .cpu_cmd_byte_addr (cpu_cmd_byte_addr),
      .cpu_rd_en         (cpu_rd_en),
      .cpu_rd_valid      (cpu_rd_valid),
      .rd_data           (rd_data),
      .mem_cmd_en        (mem_cmd_en),
      .mem_cmd_instr     (mem_cmd_instr),
      .mem_cmd_bl        (mem_cmd_bl),
      .mem_cmd_byte_addr (mem_cmd_byte_addr),
      .mem_cmd_full      (mem_cmd_full),
      .mem_rd_en         (mem_rd_en),
      .mem_rd_data       (mem_rd_data),
      .mem_rd_empty      (mem_rd_empty),
      .mem_rd_overflow   (mem_rd_overflow),
      .mem_rd_error      (mem_rd_error),
      .err               (err)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          rdy_cyc  = -1;
   int          en_cyc   = -1;
   int          c0;
   int          n_vga_pops;

   cmd_t        vq [$];
   cmd_t        cq [$];
   logic [31:0] rdq [$];
   bit          grant_log [$];
   cmd_t        issue_log [$];
   bit          pop_owner [$];
   logic [31:0] pop_data [$];
   bit          exp_grant [10];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic cmd_t mk(input logic [2:0] i, input logic [5:0] b, input logic [29:0] a);
      cmd_t c;
      c.instr = i;
      c.bl    = b;
      c.addr  = a;
      return c;
   endfunction

   task automatic apply_inputs();
      vga_cmd_valid = (vq.size() != 0);
      if (vq.size() != 0) {vga_cmd_instr, vga_cmd_bl, vga_cmd_byte_addr} = vq[0];
      else                {vga_cmd_instr, vga_cmd_bl, vga_cmd_byte_addr} = '0;
      cpu_cmd_valid = (cq.size() != 0);
      if (cq.size() != 0) {cpu_cmd_instr, cpu_cmd_bl, cpu_cmd_byte_addr} = cq[0];
      else                {cpu_cmd_instr, cpu_cmd_bl, cpu_cmd_byte_addr} = '0;
      mem_rd_empty = (rdq.size() == 0);
      mem_rd_data  = (rdq.size() != 0) ? rdq[0] : 32'h0;
   endtask

   task automatic clear_logs();
      grant_log.delete();
      issue_log.delete();
      pop_owner.delete();
      pop_data.delete();
   endtask

   // One clock: sample settled outputs, log transactions, advance, re-drive.
   task automatic run_cycle();
      bit s_vga, s_cpu, s_pop;
      #1;
      s_vga = vga_cmd_ready;
      s_cpu = cpu_cmd_ready;
      s_pop = mem_rd_en;
      if (s_vga) begin grant_log.push_back(1'b0); rdy_cyc = cyc; $display("[%0d] grant VGA", cyc); end
      if (s_cpu) begin grant_log.push_back(1'b1); rdy_cyc = cyc; $display("[%0d] grant CPU", cyc); end
      if (mem_cmd_en) begin
         issue_log.push_back(mk(mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr));
         en_cyc = cyc;
         $display("[%0d] issue instr=%0d bl=%0d addr=0x%0h", cyc, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr);
      end
      if (s_pop) begin
         pop_owner.push_back(vga_rd_valid ? 1'b0 : 1'b1);
         pop_data.push_back(rd_data);
         $display("[%0d] pop %s data=0x%08h", cyc, vga_rd_valid ? "VGA" : "CPU", rd_data);
      end
      @(posedge clk);
      cyc++;
      #1;
      if (s_pop && rdq.size() != 0) void'(rdq.pop_front());
      if (s_vga && vq.size() != 0) void'(vq.pop_front());
      if (s_cpu && cq.size() != 0) void'(cq.pop_front());
      apply_inputs();
   endtask

   initial begin
      rst = 1'b1; calib_done = 1'b0; mem_cmd_full = 1'b0;
      mem_rd_overflow = 1'b0; mem_rd_error = 1'b0;
      vga_rd_en = 1'b0; cpu_rd_en = 1'b0;
      vq.push_back(mk(3'b000, 6'd5, 30'h40));
      rdq.push_back(32'hDEAD_BEEF);
      apply_inputs();
      repeat (3) @(posedge clk);
      #1;
      // Reset state: a waiting command and a read word must not leak out.
      check_val("rst_cmd_en", mem_cmd_en, 0);
      check_val("rst_cmd_fields", {mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr}, 0);
      check_val("rst_vga_ready", vga_cmd_ready, 0);
      check_val("rst_rd_valid", {vga_rd_valid, cpu_rd_valid}, 0);
      check_val("rst_mem_rd_en", mem_rd_en, 0);
      check_val("rst_err", err, 0);
      rdq.delete();
      apply_inputs();
      rst = 1'b0;

      // Calibration hold: nothing granted while calib_done is low.
      repeat (20) run_cycle();
      check_val("calib_no_grant", grant_log.size(), 0);
      check_val("calib_no_issue", issue_log.size(), 0);
      calib_done = 1'b1;
      c0 = cyc;
      for (int i = 0; i < 10 && issue_log.size() < 1; i++) run_cycle();
      check_val("calib_ready_cycle", rdy_cyc, c0 + 1);
      check_val("calib_en_cycle", en_cyc, c0 + 2);
      check_val("calib_issue_cmd", issue_log[0], mk(3'b000, 6'd5, 30'h40));

      // Simultaneous reads: VGA first, then CPU; burst steering.
      clear_logs();
      vq.push_back(mk(3'b001, 6'd7, 30'h100));
      cq.push_back(mk(3'b001, 6'd0, 30'h200));
      apply_inputs();
      for (int i = 0; i < 20 && issue_log.size() < 2; i++) run_cycle();
      check_val("rd2_grant_count", grant_log.size(), 2);
      check_val("rd2_grant0_vga", grant_log[0], 0);
      check_val("rd2_grant1_cpu", grant_log[1], 1);
      check_val("rd2_issue0", issue_log[0], mk(3'b001, 6'd7, 30'h100));
      check_val("rd2_issue1", issue_log[1], mk(3'b001, 6'd0, 30'h200));
      for (int i = 0; i < 9; i++) rdq.push_back(32'hA000_0000 + 32'(i));
      cpu_rd_en = 1'b1;
      apply_inputs();
      repeat (3) run_cycle();
      check_val("rd2_cpu_en_no_pop", pop_data.size(), 0);
      #1;
      check_val("rd2_valid_vga_head", {vga_rd_valid, cpu_rd_valid}, 2'b10);
      vga_rd_en = 1'b1;
      for (int i = 0; i < 20 && pop_data.size() < 9; i++) run_cycle();
      n_vga_pops = 0;
      foreach (pop_owner[i]) if (pop_owner[i] == 1'b0) n_vga_pops++;
      check_val("rd2_pop_count", pop_data.size(), 9);
      check_val("rd2_vga_pops", n_vga_pops, 8);
      check_val("rd2_last_owner_cpu", pop_owner[8], 1);
      check_val("rd2_first_word", pop_data[0], 32'hA000_0000);
      check_val("rd2_cpu_word", pop_data[8], 32'hA000_0008);
      vga_rd_en = 1'b0; cpu_rd_en = 1'b0;

      // Tag FIFO full: fifth read and a CPU write are both held.
      clear_logs();
      for (int i = 0; i < 5; i++) vq.push_back(mk(3'b001, 6'd1, 30'h1000 + 30'(i * 64)));
      cq.push_back(mk(3'b000, 6'd3, 30'h2000));
      apply_inputs();
      repeat (20) run_cycle();
      check_val("full_grants", grant_log.size(), 4);
      #1;
      check_val("full_held", {vga_cmd_valid, vga_cmd_ready, cpu_cmd_ready}, 3'b100);
      rdq.push_back(32'hB000_0000);
      rdq.push_back(32'hB000_0001);
      vga_rd_en = 1'b1;
      apply_inputs();
      for (int i = 0; i < 20 && grant_log.size() < 6; i++) run_cycle();
      check_val("full_fifth_vga", {grant_log.size(), grant_log[4], grant_log[5]}, {32'd6, 2'b01});
      for (int i = 0; i < 8; i++) rdq.push_back(32'hC000_0000 + 32'(i));
      apply_inputs();
      for (int i = 0; i < 30 && pop_data.size() < 10; i++) run_cycle();
      check_val("full_drain_pops", pop_data.size(), 10);
      #1;
      check_val("full_drain_idle", {vga_rd_valid, cpu_rd_valid, mem_rd_empty}, 3'b001);
      vga_rd_en = 1'b0;

      // Command FIFO full stalls both; calib_done falling is ignored.
      clear_logs();
      calib_done = 1'b0;
      mem_cmd_full = 1'b1;
      vq.push_back(mk(3'b000, 6'd0, 30'h3000));
      cq.push_back(mk(3'b000, 6'd0, 30'h3100));
      apply_inputs();
      repeat (10) run_cycle();
      check_val("cmdfull_no_grant", grant_log.size(), 0);
      mem_cmd_full = 1'b0;
      for (int i = 0; i < 20 && grant_log.size() < 2; i++) run_cycle();
      check_val("cmdfull_release", {grant_log.size(), grant_log[0], grant_log[1]}, {32'd2, 2'b01});
      calib_done = 1'b1;

      // Both requesters always valid: priority / starvation guard.
      clear_logs();
      for (int i = 0; i < 10; i++) begin
         vq.push_back(mk(3'b000, 6'd0, 30'h4000 + 30'(i)));
         cq.push_back(mk(3'b000, 6'd0, 30'h5000 + 30'(i)));
`ifdef MEM_ARB_STARVE_GUARD_EN
         exp_grant[i] = (i == 4) || (i == 9);
`else
         exp_grant[i] = 1'b0;
`endif
      end
      apply_inputs();
      for (int i = 0; i < 40 && grant_log.size() < 10; i++) run_cycle();
      for (int i = 0; i < 10; i++) check_val($sformatf("starve_grant%0d", i), grant_log[i], exp_grant[i]);
      for (int i = 0; i < 80 && (vq.size() != 0 || cq.size() != 0); i++) run_cycle();
      check_val("starve_drained", vq.size() + cq.size(), 0);

      // Sticky error flag.
      mem_rd_error = 1'b1;
      run_cycle();
      mem_rd_error = 1'b0;
      #1;
      check_val("err_set", err, 1);
      repeat (5) run_cycle();
      check_val("err_sticky", err, 1);

      // Reset in the middle of a VGA burst.
      clear_logs();
      vq.push_back(mk(3'b001, 6'd3, 30'h6000));
      apply_inputs();
      for (int i = 0; i < 10 && issue_log.size() < 1; i++) run_cycle();
      for (int i = 0; i < 4; i++) rdq.push_back(32'hD000_0000 + 32'(i));
      vga_rd_en = 1'b1;
      apply_inputs();
      for (int i = 0; i < 10 && pop_data.size() < 2; i++) run_cycle();
      vga_rd_en = 1'b0;
      #1;
      check_val("midburst_valid", {pop_data.size(), vga_rd_valid}, {32'd2, 1'b1});
      rst = 1'b1;
      #1;
      check_val("midrst_state", {err, vga_rd_valid, cpu_rd_valid, mem_cmd_en}, 4'b0000);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_logs();
      vga_rd_en = 1'b1;
      cpu_rd_en = 1'b1;
      repeat (3) run_cycle();
      check_val("postrst_no_pop", {pop_data.size(), rdq.size()}, {32'd0, 32'd2});
      #1;
      check_val("postrst_tags_empty", {vga_rd_valid, cpu_rd_valid, mem_rd_en}, 3'b000);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single MCB user port between the VGA read path (`vga_buffer`) and the CPU memory path. Commands are arbitrated, registered and issued to the MCB command FIFO. A tag FIFO records the owner and burst length of every outstanding read, so read-FIFO words are delivered only to the requester that issued them. The block sits between the requesters and the MCB port in the top level.

## Interface
- `TAG_DEPTH`, 4: maximum outstanding read commands; power of two, at least 2.
- `STARVE_LIMIT`, 4: consecutive VGA grants allowed while the CPU waits. Used only with the guard macro.

- `clk`  in  1  system clock, 100 MHz
- `rst`  in  1  asynchronous, active-high reset
- `calib_done`  in  1  MCB calibration complete
- `vga_cmd_valid` / `cpu_cmd_valid`  in  1  command request
- `vga_cmd_ready` / `cpu_cmd_ready`  out  1  command accepted this cycle
- `vga_cmd_instr` / `cpu_cmd_instr`  in  3  MCB instruction; bit0=1 means read
- `vga_cmd_bl` / `cpu_cmd_bl`  in  6  burst length, 0-based
- `vga_cmd_byte_addr` / `cpu_cmd_byte_addr`  in  30  byte address
- `vga_rd_en` / `cpu_rd_en`  in  1  pop one read word
- `vga_rd_valid` / `cpu_rd_valid`  out  1  head word belongs to this requester
- `rd_data`  out  32  `mem_rd_data`, broadcast to both requesters
- `mem_cmd_en`, `mem_cmd_instr[2:0]`, `mem_cmd_bl[5:0]`, `mem_cmd_byte_addr[29:0]`  out  MCB command port
- `mem_cmd_full`  in  1  MCB command FIFO full
- `mem_rd_en`  out  1  MCB read-FIFO pop
- `mem_rd_data[31:0]`, `mem_rd_empty`, `mem_rd_overflow`, `mem_rd_error`  in  MCB read port
- `err`  out  1  sticky read-port fault flag

## Operation
- The FSM has three states: `S_CALIB`, `S_ARB`, `S_ISSUE`.
- Reset enters `S_CALIB`. The FSM moves to `S_ARB` on the first cycle `calib_done`=1.
- `S_ARB` accepts a command when all of the following hold:
  - at least one `*_cmd_valid` is high,
  - `mem_cmd_full`=0,
  - the tag FIFO is not full (needed only if the winning command is a read).
- Winner selection: VGA wins when both requesters are valid.
- On accept:
  - pulse the winner's `*_cmd_ready` for one cycle,
  - register the winner's instr, bl and addr into `mem_cmd_*`,
  - push the tag {owner, bl} if the command is a read,
  - go to `S_ISSUE`.
- `S_ISSUE` drives `mem_cmd_en`=1 for exactly one cycle, then returns to `S_ARB`.
- Blocking: if the winner is a read and the tag FIFO is full, nothing is accepted, even when the other requester holds a write.
- Read return:
  - The head tag owner sees `*_rd_valid` = !`mem_rd_empty` && tag FIFO non-empty.
  - `mem_rd_en` = owner's `*_rd_en` && `*_rd_valid`. The non-owner's `rd_en` is ignored.
  - The 6-bit word counter increments on each pop. When the counter equals the tag's bl, the pop clears the counter and pops the tag.
- A push and a pop of the tag FIFO in the same cycle are both performed; occupancy is unchanged.
- `err` sets on `mem_rd_overflow` or `mem_rd_error` and clears only on reset.
- `calib_done` falling after calibration is ignored; the FSM does not return to `S_CALIB`.

## Timing
- Reset values: `mem_cmd_en`=0, `mem_cmd_*`=0, both `*_cmd_ready`=0, both `*_rd_valid`=0, `mem_rd_en`=0, `err`=0, tag FIFO empty, word counter 0.
- Latency: command accepted in cycle N, `mem_cmd_en` high in cycle N+1. Peak throughput is one command per 2 cycles.
- `*_cmd_ready` and `mem_rd_en` are combinational from registered state plus the current inputs. `rd_data` is a wire.
- Requesters hold `cmd_valid` and the command fields stable until `cmd_ready`.
- Reset mid-burst discards all tags. Read words left in the MCB FIFO are not drained by this block.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - a 3-bit counter counts consecutive VGA grants while `cpu_cmd_valid`=1,
  - when the count reaches `STARVE_LIMIT`, the next arbitration goes to the CPU, even with VGA valid,
  - the counter clears on any CPU grant and on any cycle with `cpu_cmd_valid`=0.
- Not defined: strict VGA priority, no counter logic.

## Structure
- Definitions belong in `definitions.vh`:
  - MCB instruction encodings (`MCB_CMD_WR`=3'b000, `MCB_CMD_RD`=3'b001),
  - owner encoding (`OWNER_VGA`=0, `OWNER_CPU`=1),
  - FSM state encodings.
- One sub-module: `arb_tag_fifo`, a synchronous FIFO of `TAG_DEPTH`×7 bits with push, pop, full, empty and head outputs.

## Test plan
- Hold `calib_done`=0 and assert `vga_cmd_valid` for 20 cycles → no `vga_cmd_ready`, `mem_cmd_en` stays 0. Then raise `calib_done` → ready pulses after the FSM reaches `S_ARB`, and `mem_cmd_en` follows one cycle after ready.
- Issue a VGA read, bl=7, addr=0x100, and a CPU read, bl=0, in the same cycle → VGA is issued first, then the CPU. Load 9 words into the MCB read FIFO → `vga_rd_valid` for 8 pops, then `cpu_rd_valid` for 1 pop. A CPU `rd_en` asserted during the VGA burst pops nothing.
- Issue 4 reads with no data returned → the 5th read is held with ready=0. Pop the first burst → the 5th read is accepted.
- Hold `mem_cmd_full`=1 for 10 cycles with both requesters valid → no grants. Release → VGA is granted.
- With `MEM_ARB_STARVE_GUARD_EN` and both requesters always valid → the grant sequence is VGA×4, CPU, VGA×4, CPU. Without the macro → VGA only.
- Pulse `mem_rd_error` → `err`=1 and stays 1. Assert `rst` mid-burst → `err`=0, tag FIFO empty, both `rd_valid`=0.
